// File: rtl/div.sv
// Iterative 16-bit restoring divider, one quotient bit per clock; divide-by-zero returns all ones.
// Defining DIV_SIGNED_EN divides two's-complement operands by magnitude and fixes the signs on the final write.
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] divAIn,
  input  logic [15:0] divBIn,
  input  logic        divStart,
  output logic [15:0] divQuot,
  output logic [15:0] divRem,
  output logic        divBusy,
  output logic        divDone,
  output logic        divByZero
);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;       // dividend shifting out, quotient shifting in
  logic [15:0] b_q, b_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] remo_q, remo_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;

  logic        accept;
  logic [16:0] trial;
  logic        ge;
  logic [15:0] diff;
  logic [15:0] step_rem, step_quo;
  logic [15:0] a_mag, b_mag;
  logic [15:0] res_quot, res_rem;

  assign accept   = (state_q == IDLE) && divStart;
  assign trial    = {rem_q, a_q[15]};
  assign ge       = trial >= {1'b0, b_q};
  // The true difference is below the divisor, so 16 bits are enough.
  assign diff     = trial[15:0] - b_q;
  assign step_rem = ge ? diff : trial[15:0];
  assign step_quo = {a_q[14:0], ge};

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign a_mag    = divAIn[15] ? (~divAIn + 16'd1) : divAIn;
  assign b_mag    = divBIn[15] ? (~divBIn + 16'd1) : divBIn;
  assign qneg_d   = accept ? (divAIn[15] ^ divBIn[15]) : qneg_q;
  assign rneg_d   = accept ? divAIn[15] : rneg_q;
  assign res_quot = qneg_q ? (~step_quo + 16'd1) : step_quo;
  assign res_rem  = rneg_q ? (~step_rem + 16'd1) : step_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign a_mag    = divAIn;
  assign b_mag    = divBIn;
  assign res_quot = step_quo;
  assign res_rem  = step_rem;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (divStart) begin
          cnt_d = 4'd0;
          rem_d = 16'h0000;
          b_d   = b_mag;
          if (divBIn == 16'h0000) begin
            state_d = ZERO;
            a_d     = divAIn;  // raw dividend is returned as the remainder
          end else begin
            state_d = RUN;
            a_d     = a_mag;
          end
        end
      end
      RUN: begin
        a_d   = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
          quot_d  = res_quot;
          remo_d  = res_rem;
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      ZERO: begin
        state_d = IDLE;
        quot_d  = 16'hFFFF;
        remo_d  = a_q;
        dz_d    = 1'b1;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      rem_q   <= 16'h0000;
      quot_q  <= 16'h0000;
      remo_q  <= 16'h0000;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign divQuot   = quot_q;
  assign divRem    = remo_q;
  assign divBusy   = (state_q != IDLE);
  assign divDone   = done_q;
  assign divByZero = dz_q;

endmodule

// File: tb/tb_div.sv
// Bench for div: cycle-level behavioural model checked every cycle, plus directed literal vectors.
module tb_div;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] divAIn, divBIn;
  logic        divStart;
  logic [15:0] divQuot, divRem;
  logic        divBusy, divDone, divByZero;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  div dut (
    .clk      (clk),
    .reset    (reset),
    .divAIn   (divAIn),
    .divBIn   (divBIn),
    .divStart (divStart),
    .divQuot  (divQuot),
    .divRem   (divRem),
    .divBusy  (divBusy),
    .divDone  (divDone),
    .divByZero(divByZero)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_q(input logic [15:0] a, input logic [15:0] b);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa / sb);
`else
    return 16'({16'h0, a} / {16'h0, b});
`endif
  endfunction

  function automatic logic [15:0] model_r(input logic [15:0] a, input logic [15:0] b);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa % sb);
`else
    return 16'({16'h0, a} % {16'h0, b});
`endif
  endfunction

  // Model: a busy flag with a countdown to done, results from plain arithmetic.
  logic        m_busy, m_done, m_dz;
  int          m_left;
  logic [15:0] m_a, m_b, m_q, m_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
      m_q = 16'h0; m_r = 16'h0; m_a = 16'h0; m_b = 16'h0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (m_b == 16'h0) begin
            m_q = 16'hFFFF; m_r = m_a; m_dz = 1'b1;
          end else begin
            m_q = model_q(m_a, m_b); m_r = model_r(m_a, m_b); m_dz = 1'b0;
          end
        end
      end else if (divStart) begin
        m_busy = 1'b1;
        m_a    = divAIn;
        m_b    = divBIn;
        m_left = (divBIn == 16'h0) ? 1 : 16;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", divBusy, m_busy);
      chk("cyc done", divDone, m_done);
      chk("cyc quot", divQuot, m_q);
      chk("cyc rem",  divRem,  m_r);
      chk("cyc dz",   divByZero, m_dz);
    end
  end

  task automatic start(input logic [15:0] a, input logic [15:0] b);
    divAIn   = a;
    divBIn   = b;
    divStart = 1'b1;
    @(posedge clk);
    #1;
    divStart = 1'b0;
    divAIn   = 16'hDEAD;
    divBIn   = 16'hBEEF;
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [15:0] q,
                           input logic [15:0] r, input logic dz);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      #2;
      seen = divDone;
    end
    chk({nm, " latency"}, seen ? n : -1, lat);
    if (seen) begin
      chk({nm, " quot"}, divQuot, q);
      chk({nm, " rem"},  divRem, r);
      chk({nm, " dz"},   divByZero, dz);
      chk({nm, " busy"}, divBusy, 0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " quot"}, divQuot, 0);
    chk({nm, " rem"},  divRem, 0);
    chk({nm, " busy"}, divBusy, 0);
    chk({nm, " done"}, divDone, 0);
    chk({nm, " dz"},   divByZero, 0);
  endtask

  initial begin
    reset    = 1'b1;
    divStart = 1'b0;
    divAIn   = 16'h0;
    divBIn   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    chk_en = 1'b1;
    reset  = 1'b0;

    start(16'd100, 16'd7);
    wait_done("100/7", 16, 16'd14, 16'd2, 1'b0);

    start(16'hFFFF, 16'h0001);
    wait_done("FFFF/1", 16, 16'hFFFF, 16'h0000, 1'b0);
    start(16'h0003, 16'h0010);
    wait_done("3/16 b2b", 16, 16'h0000, 16'h0003, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    start(16'd1234, 16'd0);
    wait_done("1234/0", 1, 16'hFFFF, 16'd1234, 1'b1);
    start(16'd10, 16'd3);
    wait_done("10/3", 16, 16'd3, 16'd1, 1'b0);

    start(16'd500, 16'd5);
    repeat (4) @(posedge clk);
    #1;
    divAIn   = 16'd9;
    divBIn   = 16'd3;
    divStart = 1'b1;
    @(posedge clk);
    #1;
    divStart = 1'b0;
    wait_done("500/5 ign", 11, 16'd100, 16'd0, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    start(16'd500, 16'd5);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk_reset_vals("mid reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    start(16'd9, 16'd3);
    wait_done("9/3", 16, 16'd3, 16'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    start(16'hFFF9, 16'd2);
    wait_done("-7/2", 16, 16'hFFFD, 16'hFFFF, 1'b0);
    start(16'd7, 16'hFFFE);
    wait_done("7/-2", 16, 16'hFFFD, 16'h0001, 1'b0);
    start(16'h8000, 16'hFFFF);
    wait_done("8000/FFFF", 16, 16'h8000, 16'h0000, 1'b0);
    start(16'hFFF9, 16'd0);
    wait_done("-7/0", 1, 16'hFFFF, 16'hFFF9, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
